// File: rtl/fifo_pkg.sv
// Shared FIFO defaults, pointer wrap helper and error encodings.
// Pure declarations; no latency or backpressure of its own.
package fifo_pkg;

  localparam int DEF_BITNUMBER = 6;
  localparam int DEF_LENGTH    = 4;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'b00,
    ERR_OVERFLOW  = 2'b01,
    ERR_UNDERFLOW = 2'b10
  } fifo_err_e;

  // Explicit compare so depths that are not a power of two wrap correctly.
  function automatic int ptr_next(input int ptr, input int len);
    return (ptr == len - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_buffer_if.sv
// Producer/consumer side of the FIFO: requests, write data, thresholds and status.
// Zero latency wiring; backpressure is visible to the producer as Fifo_full.
interface fifo_buffer_if #(
  parameter int BITNUMBER = fifo_pkg::DEF_BITNUMBER,
  parameter int LENGTH    = fifo_pkg::DEF_LENGTH
);
  localparam int CNTW = $clog2(LENGTH + 1);

  logic                 Fifo_wr;
  logic                 Fifo_rd;
  logic [BITNUMBER-1:0] data_in;
  logic [CNTW-1:0]      almost_full_th;
  logic [CNTW-1:0]      almost_empty_th;
  logic [BITNUMBER-1:0] data_out;
  logic                 valid_out;
  logic                 Fifo_full;
  logic                 Fifo_empty;
  logic                 almost_full;
  logic                 almost_empty;
  logic                 fifo_error;
  logic [CNTW-1:0]      count;

  modport master (
    output Fifo_wr, Fifo_rd, data_in, almost_full_th, almost_empty_th,
    input  data_out, valid_out, Fifo_full, Fifo_empty, almost_full,
           almost_empty, fifo_error, count
  );

  modport slave (
    input  Fifo_wr, Fifo_rd, data_in, almost_full_th, almost_empty_th,
    output data_out, valid_out, Fifo_full, Fifo_empty, almost_full,
           almost_empty, fifo_error, count
  );

endinterface

// File: rtl/fifo_ram.sv
// LENGTH x BITNUMBER register array, synchronous write, registered read (1 cycle).
// No backpressure; the read register holds its value when re is low.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int BITNUMBER = DEF_BITNUMBER,
  parameter int LENGTH    = DEF_LENGTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         we,
  input  logic [$clog2(LENGTH)-1:0]    waddr,
  input  logic [BITNUMBER-1:0]         wdata,
  input  logic                         re,
  input  logic [$clog2(LENGTH)-1:0]    raddr,
  output logic [BITNUMBER-1:0]         rdata
);

  logic [BITNUMBER-1:0] mem [LENGTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register is reset so data_out comes up as zero; the array is not.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo_buffer.sv
// Synchronous FIFO with count-decoded status flags and sticky overflow/underflow error.
// Read data one cycle after an accepted read; writes to a full FIFO are dropped unless paired with a read.
module fifo_buffer
  import fifo_pkg::*;
#(
  parameter int BITNUMBER = DEF_BITNUMBER,
  parameter int LENGTH    = DEF_LENGTH
) (
  input  logic         clk,
  input  logic         reset,
  fifo_buffer_if.slave bus
);

  localparam int PTRW = $clog2(LENGTH);
  localparam int CNTW = $clog2(LENGTH + 1);

  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic [CNTW-1:0] count_q;
  logic            valid_q;
  logic            error_q;
  logic            full;
  logic            empty;
  logic            wr_ok;
  logic            rd_ok;
  logic            overflow;
  logic            underflow;

  assign full      = (count_q == CNTW'(LENGTH));
  assign empty     = (count_q == '0);
  assign wr_ok     = bus.Fifo_wr && (!full || bus.Fifo_rd);
  assign rd_ok     = bus.Fifo_rd && !empty;
  assign overflow  = bus.Fifo_wr && full && !bus.Fifo_rd;
  assign underflow = bus.Fifo_rd && empty;

  fifo_ram #(
    .BITNUMBER (BITNUMBER),
    .LENGTH    (LENGTH)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (bus.data_in),
    .re    (rd_ok),
    .raddr (rd_ptr),
    .rdata (bus.data_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= PTRW'(ptr_next(int'(wr_ptr), LENGTH));
      if (rd_ok) rd_ptr <= PTRW'(ptr_next(int'(rd_ptr), LENGTH));
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + CNTW'(1);
        2'b01:   count_q <= count_q - CNTW'(1);
        default: count_q <= count_q;
      endcase
      valid_q <= rd_ok;
      if (overflow || underflow) error_q <= 1'b1;
    end
  end

  // Flags are pure decodes of count so they move on the same edge as the data.
  assign bus.valid_out    = valid_q;
  assign bus.fifo_error   = error_q;
  assign bus.count        = count_q;
  assign bus.Fifo_full    = full;
  assign bus.Fifo_empty   = empty;
  assign bus.almost_full  = (count_q >= bus.almost_full_th);
  assign bus.almost_empty = (count_q <= bus.almost_empty_th);

endmodule

// File: tb/tb_fifo_buffer.sv
// Directed plus randomized test of fifo_buffer against a queue-based reference model.
module tb_fifo_buffer;

  localparam int BW  = 6;
  localparam int LEN = 4;
  localparam int CW  = $clog2(LEN + 1);

  logic clk;
  logic reset;

  fifo_buffer_if #(.BITNUMBER(BW), .LENGTH(LEN)) bus ();

  fifo_buffer #(.BITNUMBER(BW), .LENGTH(LEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  logic [BW-1:0] q[$];
  logic [BW-1:0] m_dout;
  logic          m_valid;
  logic          m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int sz;
    sz = q.size();
    check({tag, ".data_out"},     32'(bus.data_out),     32'(m_dout));
    check({tag, ".valid_out"},    32'(bus.valid_out),    32'(m_valid));
    check({tag, ".count"},        32'(bus.count),        sz);
    check({tag, ".Fifo_full"},    32'(bus.Fifo_full),    32'(sz == LEN));
    check({tag, ".Fifo_empty"},   32'(bus.Fifo_empty),   32'(sz == 0));
    check({tag, ".almost_full"},  32'(bus.almost_full),  32'(sz >= int'(bus.almost_full_th)));
    check({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(sz <= int'(bus.almost_empty_th)));
    check({tag, ".fifo_error"},   32'(bus.fifo_error),   32'(m_err));
  endtask

  task automatic model_reset();
    q.delete();
    m_dout  = '0;
    m_valid = 1'b0;
    m_err   = 1'b0;
  endtask

  // One clock: drive requests, let the edge happen, advance the model, compare.
  task automatic cycle(input logic wr, input logic rd, input logic [BW-1:0] din, input string tag);
    bit full_b, empty_b, wr_acc, rd_acc;
    bus.Fifo_wr = wr;
    bus.Fifo_rd = rd;
    bus.data_in = din;
    @(posedge clk);
    full_b  = (q.size() == LEN);
    empty_b = (q.size() == 0);
    wr_acc  = wr && (!full_b || rd);
    rd_acc  = rd && !empty_b;
    if ((wr && full_b && !rd) || (rd && empty_b)) m_err = 1'b1;
    m_valid = rd_acc;
    if (rd_acc) m_dout = q.pop_front();
    if (wr_acc) q.push_back(din);
    #1;
    bus.Fifo_wr = 1'b0;
    bus.Fifo_rd = 1'b0;
    check_all(tag);
  endtask

  // Asynchronous pulse placed between edges.
  task automatic pulse_reset(input string tag);
    reset = 1'b0;
    #2;
    model_reset();
    check_all(tag);
    reset = 1'b1;
    #1;
  endtask

  initial begin
    bus.Fifo_wr         = 1'b0;
    bus.Fifo_rd         = 1'b0;
    bus.data_in         = '0;
    bus.almost_full_th  = CW'(3);
    bus.almost_empty_th = CW'(1);
    model_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset_hold");
    reset = 1'b1;
    #1;
    check_all("reset_release");

    // Fill and overflow
    for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b0, BW'(i), $sformatf("fill%0d", i));
    check("fill.full_flag", 32'(bus.Fifo_full), 32'd1);
    cycle(1'b1, 1'b0, 6'h3F, "overflow");
    check("overflow.err", 32'(bus.fifo_error), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b0, 1'b1, '0, $sformatf("drain%0d", i));
      check($sformatf("drain%0d.value", i), 32'(bus.data_out), i);
    end

    // Simultaneous read/write on full
    pulse_reset("rst_a");
    for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b0, BW'(i), $sformatf("refill%0d", i));
    cycle(1'b1, 1'b1, 6'h15, "full_rw");
    check("full_rw.dout", 32'(bus.data_out), 32'h01);
    check("full_rw.count", 32'(bus.count), 32'd4);

    // Simultaneous read/write on empty
    pulse_reset("rst_b");
    cycle(1'b1, 1'b1, 6'h2A, "empty_rw");
    check("empty_rw.valid", 32'(bus.valid_out), 32'd0);
    check("empty_rw.err", 32'(bus.fifo_error), 32'd1);
    cycle(1'b0, 1'b1, '0, "empty_rw_read");
    check("empty_rw_read.dout", 32'(bus.data_out), 32'h2A);

    // Wrap-around
    pulse_reset("rst_c");
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, BW'(i), $sformatf("wrap_w%0d", i));
      cycle(1'b0, 1'b1, '0, $sformatf("wrap_r%0d", i));
      check($sformatf("wrap_r%0d.value", i), 32'(bus.data_out), i);
    end
    check("wrap.count", 32'(bus.count), 32'd0);

    // Reset mid-fill
    pulse_reset("rst_d");
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, BW'(i + 8), $sformatf("midfill%0d", i));
    pulse_reset("rst_mid");
    check("rst_mid.empty", 32'(bus.Fifo_empty), 32'd1);
    cycle(1'b1, 1'b0, 6'h07, "post_rst_w");
    cycle(1'b0, 1'b1, '0, "post_rst_r");
    check("post_rst_r.value", 32'(bus.data_out), 32'h07);

    // Randomized traffic with threshold corners
    pulse_reset("rst_rand");
    for (int i = 0; i < 400; i++) begin
      if (i == 130) begin
        bus.almost_full_th  = CW'(0);
        bus.almost_empty_th = CW'(LEN);
      end
      if (i == 260) begin
        bus.almost_full_th  = CW'(LEN);
        bus.almost_empty_th = CW'(0);
      end
      if (i == 330) pulse_reset("rst_rand_mid");
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            BW'($urandom_range(0, 63)), $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_buffer.md
# fifo_buffer

Synchronous FIFO storing BITNUMBER-bit words. It produces the Fifo_full, Fifo_empty, almost_full and almost_empty status flags that the flow-control stage directly downstream turns into pause and can_pop. It also reports overflow and underflow. It sits between the data producer and the consumer, and is the only storage in the path.

## Interface
- BITNUMBER, 6, data word width.
- LENGTH, 4, depth in words; any integer ≥ 2.
- PTRW, $clog2(LENGTH), read/write pointer width (derived; do not override).
- CNTW, $clog2(LENGTH+1), occupancy/threshold width (derived).

- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- Fifo_wr  in  1  write request; data_in sampled on the same edge.
- Fifo_rd  in  1  read request.
- data_in  in  BITNUMBER  write data.
- almost_full_th  in  CNTW  almost-full threshold, 0..LENGTH; quasi-static.
- almost_empty_th  in  CNTW  almost-empty threshold, 0..LENGTH; quasi-static.
- data_out  out  BITNUMBER  registered read data.
- valid_out  out  1  pulses high for one cycle when data_out was loaded by an accepted read.
- Fifo_full  out  1  count == LENGTH.
- Fifo_empty  out  1  count == 0.
- almost_full  out  1  count >= almost_full_th.
- almost_empty  out  1  count <= almost_empty_th.
- fifo_error  out  1  sticky overflow/underflow indicator.
- count  out  CNTW  current occupancy.

## Operation
- State:
  - storage array mem[LENGTH];
  - wr_ptr and rd_ptr (PTRW bits);
  - count (CNTW bits);
  - data_out, valid_out and fifo_error registers.
- Write acceptance: wr_ok = Fifo_wr && (!Fifo_full || Fifo_rd).
  - Full with simultaneous read: both operations are accepted and count is unchanged.
- Read acceptance: rd_ok = Fifo_rd && !Fifo_empty.
  - Empty with simultaneous write: the write is accepted and the read is rejected. A read never bypasses the write (no fall-through).
- On wr_ok:
  - mem[wr_ptr] <= data_in;
  - wr_ptr advances, wrapping from LENGTH-1 to 0 by explicit compare (no power-of-two assumption).
- On rd_ok:
  - data_out <= mem[rd_ptr];
  - rd_ptr advances with the same wrap rule;
  - valid_out <= 1.
  - Otherwise valid_out <= 0 and data_out holds its value.
- count update:
  - +1 on wr_ok only;
  - -1 on rd_ok only;
  - unchanged when both or neither occur.
- Overflow is Fifo_wr && Fifo_full && !Fifo_rd. The write is dropped and fifo_error <= 1.
- Underflow is Fifo_rd && Fifo_empty. The read is ignored, data_out and the pointers are unchanged, and fifo_error <= 1.
- fifo_error stays set until reset.
- Flags and count output are combinational decodes of the count register. They carry no state of their own.
- Threshold corner cases:
  - almost_full_th = 0 gives almost_full permanently 1.
  - almost_empty_th = LENGTH gives almost_empty permanently 1.
  - Both are legal and must not be special-cased.

## Timing
- Reset is asserted asynchronously. It is released synchronously by the environment.
- Values while reset is low:
  - wr_ptr, rd_ptr, count = 0;
  - data_out = 0, valid_out = 0, fifo_error = 0;
  - Fifo_empty = 1, Fifo_full = 0, almost_empty = 1;
  - almost_full = (almost_full_th == 0).
  - mem is not reset.
- Reset asserted mid-operation discards all contents immediately; the next cycle behaves as empty.
- Write latency: data written at edge k is readable by a Fifo_rd sampled at edge k+1. Fifo_empty falls right after edge k.
- Read latency: a Fifo_rd accepted at edge k presents data_out and valid_out immediately after edge k. Data is one cycle behind the request.
- Flag latency: every flag reflects the operations of edge k immediately after edge k, with zero added cycles. This lets the downstream flow-control stage react in the same cycle.
- Back-to-back reads and writes every cycle are supported at full rate.

## Structure
- Shared package fifo_pkg holds:
  - default BITNUMBER and LENGTH;
  - the pointer-increment-with-wrap function;
  - overflow/underflow encodings, if later split into separate bits.
- One sub-module, fifo_ram:
  - a LENGTH x BITNUMBER register array;
  - one synchronous write port and one registered read port (we, waddr, wdata, re, raddr, rdata).
- fifo_buffer keeps the pointers, count, flags and error logic.

## Test plan
All scenarios use LENGTH=4, BITNUMBER=6, almost_full_th=3, almost_empty_th=1.
- Reset: hold reset=0 for 2 cycles, then release. Expect Fifo_empty=1, almost_empty=1, Fifo_full=0, almost_full=0, count=0, fifo_error=0, data_out=0.
- Fill: write 0x01, 0x02, 0x03, 0x04 on consecutive cycles.
  - After the 1st write: count=1, Fifo_empty=0, almost_empty=1.
  - After the 2nd write: almost_empty=0.
  - After the 3rd write: almost_full=1.
  - After the 4th write: Fifo_full=1, fifo_error=0.
- Overflow: with the FIFO full, Fifo_wr=1 with data 0x3F and Fifo_rd=0. Expect count stays 4, fifo_error=1. A subsequent drain returns 0x01..0x04; 0x3F never appears.
- Simultaneous read and write:
  - On a full FIFO, write 0x15 while reading. Expect data_out=0x01, count=4, no error.
  - Next, on an empty FIFO after reset, assert Fifo_rd and Fifo_wr with 0x2A together. Expect count=1, valid_out=0, fifo_error=1.
- Wrap-around: perform 10 write/read pairs of 0x00..0x09. Expect data_out to sequence 0x00..0x09 with one-cycle latency, and count to return to 0.
- Reset mid-fill: after 3 writes, pulse reset low between edges. Expect count=0 and Fifo_empty=1 asynchronously. The next write of 0x07 followed by a read returns 0x07.
